fnd_digit_scanner: RTL
======================

// Module: fnd_digit_scanner
// PURPOSE
//  Free-running multiplexed digit scanner for the FND (7-segment) display. Generalises the
//  static digit-select decoder to NUM_DIGITS digits. Adds a per-digit enable mask that skips
//  unused digits, PWM brightness control and anti-ghosting dead time. Sits between the
//  display data path and the anode pins; o_digit_index steers the external segment-data mux.
// PARAMETERS
//  NUM_DIGITS  4            number of digits scanned (>=2)
//  CLK_HZ      100_000_000  i_clk frequency
//  SCAN_HZ     1_000        digit slots per second; TICK_DIV = CLK_HZ/SCAN_HZ (>= DEADTIME+2)
//  BRIGHT_W    3            brightness code width; PWM period = 2**BRIGHT_W clocks
//  DEADTIME    2            blank clocks at the start of each digit slot
// PORTS
//  i_clk            in   1                  system clock
//  i_reset          in   1                  asynchronous, active-high reset
//  i_pwswitch       in   1                  1 = blank display (all anodes off)
//  i_enable_mask    in   NUM_DIGITS         bit n = 1 -> digit n is scanned
//  i_brightness     in   BRIGHT_W           0 = dimmest, all-ones = full on
//  o_digitposition  out  NUM_DIGITS         active-low anode select, one-cold or all-ones
//  o_digit_index    out  $clog2(NUM_DIGITS) index of the currently selected digit
//  o_digit_tick     out  1                  1-clock pulse on the cycle the index changes
// BEHAVIOUR
//  - Single clock domain. i_reset is asynchronous and active-high. All outputs are registered.
//  - Reset values: prescaler=0, pwm=0, dead=DEADTIME, o_digit_index=0, o_digit_tick=0,
//    o_digitposition=all ones.
//  - Prescaler counts 0..TICK_DIV-1 and wraps. At terminal count, the index loads the next
//    enabled digit, searched from index+1 upward and wrapping NUM_DIGITS-1 -> 0.
//    o_digit_tick pulses in the same cycle the new index appears.
//  - If the only enabled digit is the current one, the index holds, but the tick still pulses
//    and dead time restarts.
//  - If i_enable_mask == 0, the index holds, no tick is generated and the output is all ones.
//  - Dead counter reloads to DEADTIME on each tick. While dead != 0, the output is all ones.
//  - PWM counter is free-running, modulo 2**BRIGHT_W. The digit is driven only when
//    pwm <= i_brightness.
//  - o_digitposition = ~(1 << o_digit_index) when all of the following hold:
//    !i_pwswitch, dead == 0, mask[index] == 1 and the PWM condition.
//    Otherwise it is all ones. Output changes 1 clock after any input change.
//  - i_pwswitch blanks the output only. Prescaler, index and tick keep running, so scanning
//    resumes seamlessly when the display is un-blanked.
//  - Mask change mid-slot: if mask[index] drops, the digit blanks next clock and the index
//    advances at the next terminal count.
//  - o_digit_index and o_digitposition always change in the same cycle, so the segment mux
//    needs no extra alignment.
//  - Reset mid-slot: everything returns to reset values immediately (asynchronously).
// STRUCTURE
//  - fnd_pkg holds:
//      function tick_div(clk_hz, scan_hz)
//      localparam-style macro for the index width ($clog2, min 1)
//      constant ALL_OFF (all-ones anode pattern)
//  - Sub-module scan_prescaler: parametrised modulo-N counter with a terminal-count pulse.
//    It is reused for the PWM counter.
//  - Top level holds the next-enabled search (combinational priority rotate), the dead
//    counter and the output register.
// TESTING (bench params: CLK_HZ=1000, SCAN_HZ=100 -> TICK_DIV=10, DEADTIME=2, BRIGHT_W=2)
//  - Reset, then mask=4'hF, brightness=3 -> index 0,1,2,3,0, each for 10 clocks.
//    o_digitposition is 1111 for 2 clocks, then 1110/1101/1011/0111 for 8 clocks.
//    Tick pulses every 10th clock.
//  - mask=4'b0101 -> index sequence 0,2,0,2; digits 1 and 3 are never driven low.
//  - mask=0 -> output stays 1111, no ticks, index frozen. Then mask=4'b1000 -> index 3
//    at the next terminal count.
//  - brightness=0 with the slot open -> digit low 1 of every 4 clocks. brightness=1 -> low
//    2 of 4. brightness=3 -> continuously low.
//  - i_pwswitch=1 for 25 clocks -> output 1111 while ticks continue. On release, the index
//    matches an undisturbed reference count.
//  - Assert i_reset asynchronously mid-slot -> outputs 1111/0/0 without waiting for a clock
//    edge. The first tick comes 10 clocks after release.

Source files
------------

// File: rtl/fnd_digit_scanner_pkg.sv
// fnd_digit_scanner_pkg: shared constants and sizing helpers for the FND digit scanner
//   tick_div(clk_hz, scan_hz) : clocks per digit slot
//   idx_w(n)                  : counter/index width for n states, never below 1
//   ALL_OFF                   : all-anodes-off pattern, sliced to the digit count
package fnd_digit_scanner_pkg;

    localparam logic [63:0] ALL_OFF = '1;

    function automatic int tick_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fnd_digit_scanner_prescaler.sv
// fnd_digit_scanner_prescaler: free-running modulo-N counter with terminal-count flag
//   clk, rst : clock and asynchronous active-high reset
//   cnt      : current count 0..N-1
//   tc       : high while cnt == N-1, so the next edge wraps to 0
module fnd_digit_scanner_prescaler
    import fnd_digit_scanner_pkg::*;
#(
    parameter int N = 10,
    parameter int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(N - 1));

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= tc ? '0 : cnt + 1'b1;

endmodule

// File: rtl/fnd_digit_scanner.sv
// fnd_digit_scanner: multiplexed FND anode scanner with enable mask, PWM dimming and dead time
//   i_clk, i_reset   : clock and asynchronous active-high reset
//   i_pwswitch       : 1 blanks all anodes, scanning keeps running
//   i_enable_mask    : bit n set -> digit n takes part in the scan
//   i_brightness     : digit is lit while pwm phase <= this code
//   o_digitposition  : active-low one-cold anode select, all ones when blank
//   o_digit_index    : digit currently selected, steers the segment-data mux
//   o_digit_tick     : one-clock pulse on the cycle the index (re)loads
module fnd_digit_scanner
    import fnd_digit_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1_000,
    parameter int BRIGHT_W   = 3,
    parameter int DEADTIME   = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_pwswitch,
    input  logic [NUM_DIGITS-1:0]       i_enable_mask,
    input  logic [BRIGHT_W-1:0]         i_brightness,
    output logic [NUM_DIGITS-1:0]       o_digitposition,
    output logic [idx_w(NUM_DIGITS)-1:0] o_digit_index,
    output logic                        o_digit_tick
);

    localparam int TICK_DIV = tick_div(CLK_HZ, SCAN_HZ);
    localparam int IW       = idx_w(NUM_DIGITS);
    localparam int DW       = idx_w(DEADTIME + 1);
    localparam logic [NUM_DIGITS-1:0] OFF = ALL_OFF[NUM_DIGITS-1:0];

    logic                  scan_tc, pwm_tc, tick;
    logic [idx_w(TICK_DIV)-1:0] presc_unused;
    logic [BRIGHT_W-1:0]   pwm, pwm_nxt;
    logic [DW-1:0]         dead, dead_nxt;
    logic [IW-1:0]         seek, probe, idx_nxt;

    fnd_digit_scanner_prescaler #(.N(TICK_DIV)) u_presc (
        .clk (i_clk),
        .rst (i_reset),
        .cnt (presc_unused),
        .tc  (scan_tc)
    );

    fnd_digit_scanner_prescaler #(.N(2 ** BRIGHT_W), .W(BRIGHT_W)) u_pwm (
        .clk (i_clk),
        .rst (i_reset),
        .cnt (pwm),
        .tc  (pwm_tc)
    );

    // Walk offsets from farthest to nearest so the nearest enabled digit above
    // the current one wins; with no other digit enabled the index stays put.
    always_comb begin
        seek  = o_digit_index;
        probe = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            probe = IW'((int'(o_digit_index) + i) % NUM_DIGITS);
            if (i_enable_mask[probe]) seek = probe;
        end
    end

    assign tick     = scan_tc && (|i_enable_mask);
    assign idx_nxt  = tick ? seek : o_digit_index;
    assign dead_nxt = tick ? DW'(DEADTIME) : (dead != '0 ? dead - 1'b1 : dead);
    // Output is decided from next-state values so anode and index move together.
    assign pwm_nxt  = pwm_tc ? '0 : pwm + 1'b1;

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            dead            <= DW'(DEADTIME);
            o_digit_index   <= '0;
            o_digit_tick    <= 1'b0;
            o_digitposition <= OFF;
        end else begin
            dead            <= dead_nxt;
            o_digit_index   <= idx_nxt;
            o_digit_tick    <= tick;
            o_digitposition <= (!i_pwswitch && dead_nxt == '0 && i_enable_mask[idx_nxt] &&
                                pwm_nxt <= i_brightness) ? ~(NUM_DIGITS'(1) << idx_nxt) : OFF;
        end

endmodule
